// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter.
// Scan codes are queued in a small FIFO and sent one at a time as 11-bit
// frames (start, 8 data bits LSB first, odd parity, stop) on ps2_clk/ps2_data.
// Both PS/2 lines are registered from the FSM state, so they lag the state by
// one cycle and ps2_data only moves together with a ps2_clk rise.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code_data,
    output logic       code_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam int DIV_LAST_I = CLK_DIV - 1;
    localparam int GAP_LAST_I = GAP_CYCLES - 1;

    localparam logic [CW-1:0] DIV_LAST = DIV_LAST_I[CW-1:0];
    localparam logic [CW-1:0] GAP_LAST = GAP_LAST_I[CW-1:0];
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [3:0]    LAST_BIT = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        GAP
    } state_t;

    // Start bit, data LSB first, odd parity, stop bit; b0 sits in bit 0.
    function automatic logic [10:0] build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    bit_idx;
    logic [3:0]    bit_idx_nxt;
    logic [10:0]   frame;

    // Ready comes from the registered count only, so a pop in the same cycle
    // cannot open a slot for a push.
    assign code_ready = (count != FULL_CNT);
    assign push       = code_valid && code_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign busy       = (state != IDLE) || (count != '0);

    // FIFO storage: data only, pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= code_data;
        end
    end

    // FIFO pointers and occupancy; reset discards every queued code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame shifter loaded on pop; its contents only matter in HIGH/LOW.
    always_ff @(posedge clk) begin
        if (pop) begin
            frame <= build_frame(fifo_mem[rd_ptr]);
        end
    end

    // FSM state, half-period/gap counter and bit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Next-state: each HIGH and LOW lasts CLK_DIV cycles, GAP lasts GAP_CYCLES.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt   = HIGH;
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                end
            end
            HIGH: begin
                if (cnt == DIV_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt   = HIGH;
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered PS/2 lines; bit_idx is stable across HIGH and LOW of a bit,
    // so data changes only in step with the clock rising.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            ps2_clk  <= (state != LOW);
            ps2_data <= ((state == HIGH) || (state == LOW)) ? frame[bit_idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: two instances (CLK_DIV 4 and 2) sharing clock and reset.
// A cycle-level occupancy/timing model predicts ready and busy for instance A;
// line monitors decode frames and compare bytes against the accepted pushes.
module tb_ps2_kbd_tx;

    localparam int CD_A     = 4;
    localparam int CD_B     = 2;
    localparam int GAP      = 32;
    localparam int DEPTH    = 4;
    localparam int PERIOD_A = 22 * CD_A + GAP + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       ready_a, pclk_a, pdat_a, busy_a;
    logic       valid_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       ready_b, pclk_b, pdat_b, busy_b;

    always #5 clk = ~clk;

    ps2_kbd_tx #(.CLK_DIV(CD_A), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .code_valid(valid_a), .code_data(data_a),
        .code_ready(ready_a), .ps2_clk(pclk_a), .ps2_data(pdat_a), .busy(busy_a)
    );

    ps2_kbd_tx #(.CLK_DIV(CD_B), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .code_valid(valid_b), .code_data(data_b),
        .code_ready(ready_b), .ps2_clk(pclk_b), .ps2_data(pdat_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model of instance A: queued entries and the edge at which the
    // transmitter becomes idle again after the last pop.
    int m_cnt = 0;
    int m_busy_until = -1;
    logic [7:0] expq_a[$];
    logic [7:0] expq_b[$];
    int start_a[$];
    int fall_a[$];
    int frames_a = 0;
    int frames_b = 0;
    int bitn_a = 0;
    int bitn_b = 0;
    logic [10:0] last_a = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_busy_until = -1;
        expq_a.delete();
        expq_b.delete();
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic tick();
        bit pop_m, push_m;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            pop_m  = (m_cnt > 0) && (cyc >= m_busy_until + 1);
            push_m = valid_a && (m_cnt < DEPTH);
            if (pop_m) begin
                m_busy_until = cyc + 22 * CD_A + GAP;
                m_cnt--;
            end
            if (push_m) begin
                m_cnt++;
                expq_a.push_back(data_a);
            end
        end
        @(negedge clk);
        chk("ready_a", ready_a, m_cnt < DEPTH);
        chk("busy_a", busy_a, (m_cnt > 0) || (cyc < m_busy_until));
    endtask

    task automatic wait_frames_a(input int n, input int budget);
        int k = 0;
        while (frames_a < n && k < budget) begin
            tick();
            k++;
        end
        chk("a_frame_timeout", frames_a >= n, 1);
    endtask

    // Line monitor for instance A: decode frames, phase lengths, data stability.
    initial begin
        logic pc, pd;
        int run;
        logic [10:0] bits;
        pc = 1'b1; pd = 1'b1; run = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pc = 1'b1; pd = 1'b1; run = 0; bitn_a = 0;
            end else begin
                if (pdat_a !== pd) chk("a_data_stable", pclk_a, 1);
                if (bitn_a == 0 && pd == 1'b1 && pdat_a == 1'b0 && pclk_a == 1'b1)
                    start_a.push_back(cyc);
                if (pclk_a === pc) begin
                    run++;
                end else begin
                    if (pc == 1'b0 || bitn_a > 0) chk("a_phase_len", run, CD_A);
                    run = 1;
                    if (pc == 1'b1) begin
                        if (bitn_a == 0) fall_a.push_back(cyc);
                        bits[bitn_a] = pdat_a;
                        bitn_a++;
                        if (bitn_a == 11) begin
                            chk("a_start_bit", bits[0], 0);
                            chk("a_stop_bit", bits[10], 1);
                            chk("a_odd_ones", $countones(bits[9:1]) % 2, 1);
                            if (expq_a.size() == 0) chk("a_unexpected_frame", bits, 0);
                            else chk("a_byte", bits[8:1], expq_a.pop_front());
                            last_a = bits;
                            frames_a++;
                            bitn_a = 0;
                        end
                    end
                end
                pc = pclk_a;
                pd = pdat_a;
            end
        end
    end

    // Line monitor for instance B.
    initial begin
        logic pc, pd;
        int run;
        logic [10:0] bits;
        pc = 1'b1; pd = 1'b1; run = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pc = 1'b1; pd = 1'b1; run = 0; bitn_b = 0;
            end else begin
                if (pdat_b !== pd) chk("b_data_stable", pclk_b, 1);
                if (pclk_b === pc) begin
                    run++;
                end else begin
                    if (pc == 1'b0 || bitn_b > 0) chk("b_phase_len", run, CD_B);
                    run = 1;
                    if (pc == 1'b1) begin
                        bits[bitn_b] = pdat_b;
                        bitn_b++;
                        if (bitn_b == 11) begin
                            chk("b_start_bit", bits[0], 0);
                            chk("b_stop_bit", bits[10], 1);
                            chk("b_odd_ones", $countones(bits[9:1]) % 2, 1);
                            if (expq_b.size() == 0) chk("b_unexpected_frame", bits, 0);
                            else chk("b_byte", bits[8:1], expq_b.pop_front());
                            frames_b++;
                            bitn_b = 0;
                        end
                    end
                end
                pc = pclk_b;
                pd = pdat_b;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n0, n1, k, pushed_b;
        logic [7:0]  pc_code [3];
        logic [10:0] pc_exp  [3];
        pc_code = '{8'h00, 8'hFF, 8'h01};
        pc_exp  = '{11'b11000000000, 11'b11111111110, 11'b10000000010};
        pushed_b = 0;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_ps2_clk", pclk_a, 1);
        chk("rst_ps2_data", pdat_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", ready_a, 1);
        rst = 1'b1;
        repeat (2) tick();

        // Single code 0x1C: latency, bit pattern, gap
        start_a.delete(); fall_a.delete();
        n0 = frames_a;
        valid_a = 1'b1; data_a = 8'h1C;
        tick();
        t0 = cyc;
        valid_a = 1'b0;
        wait_frames_a(n0 + 1, 400);
        chk("x1c_bits", last_a, 11'b10000111000);
        chk("x1c_start_edge", start_a.size() > 0 ? start_a[0] : -1, t0 + 2);
        chk("x1c_first_fall", fall_a.size() > 0 ? fall_a[0] : -1, t0 + 2 + CD_A);
        k = 0;
        while (pclk_a !== 1'b1 && k < 20) begin tick(); k++; end
        repeat (GAP - 1) begin
            tick();
            chk("x1c_gap_lines", {pclk_a, pdat_a}, 2'b11);
        end
        repeat (4) tick();
        chk("x1c_busy_after", busy_a, 0);

        // Parity corners
        for (int i = 0; i < 3; i++) begin
            n0 = frames_a;
            valid_a = 1'b1; data_a = pc_code[i];
            tick();
            valid_a = 1'b0;
            wait_frames_a(n0 + 1, 400);
            chk("parity_bits", last_a, pc_exp[i]);
        end
        repeat (PERIOD_A) tick();

        // Burst 0x10..0x15 with random junk held on the bus while full
        start_a.delete();
        n0 = frames_a;
        for (int i = 0; i < 6; i++) begin
            k = 0;
            valid_a = 1'b1;
            while (!ready_a && k < 400) begin
                data_a = 8'($urandom);
                tick();
                k++;
            end
            data_a = 8'(8'h10 + i);
            tick();
            if (i == 4) chk("burst_full_ready", ready_a, 0);
        end
        valid_a = 1'b0;
        wait_frames_a(n0 + 6, 6 * PERIOD_A + 200);
        for (int i = 1; i < 6; i++)
            chk("burst_spacing", start_a.size() > i ? start_a[i] - start_a[i-1] : -1, PERIOD_A);
        chk("burst_queue_empty", expq_a.size(), 0);
        repeat (PERIOD_A) tick();

        // Reset during b5 with two codes queued
        valid_a = 1'b1;
        data_a = 8'h21; tick();
        data_a = 8'h22; tick();
        data_a = 8'h23; tick();
        valid_a = 1'b0;
        k = 0;
        while (!(bitn_a == 5 && pclk_a == 1'b1) && k < 200) begin tick(); k++; end
        chk("reach_b5", bitn_a, 5);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_lines", {pclk_a, pdat_a}, 2'b11);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_ready", ready_a, 1);
        valid_a = 1'b1; data_a = 8'h77;
        repeat (3) tick();
        valid_a = 1'b0;
        rst = 1'b1;
        n1 = frames_a;
        repeat (300) tick();
        chk("postrst_no_frames", frames_a, n1);
        chk("postrst_idle_lines", {pclk_a, pdat_a}, 2'b11);
        valid_a = 1'b1; data_a = 8'h5A;
        tick();
        valid_a = 1'b0;
        wait_frames_a(n1 + 1, 400);
        chk("x5a_bits", last_a, 11'b11010110100);
        repeat (PERIOD_A) tick();

        // Random traffic into the CLK_DIV=2 instance
        for (int i = 0; i < 2500; i++) begin
            valid_b = ($urandom_range(0, 3) == 0);
            data_b  = 8'($urandom);
            if (valid_b && ready_b) begin
                expq_b.push_back(data_b);
                pushed_b++;
            end
            tick();
        end
        valid_b = 1'b0;
        k = 0;
        while (frames_b < pushed_b && k < 1000) begin tick(); k++; end
        chk("b_drained", frames_b, pushed_b);
        chk("b_queue_empty", expq_b.size(), 0);
        chk("b_pushed_some", pushed_b > 10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 transmitter that emulates a keyboard. It accepts 8-bit scan codes on a valid/ready interface, buffers them in a small FIFO, and serialises each one as an 11-bit PS/2 device-to-host frame on `ps2_clk`/`ps2_data`. It sits in the test and stimulus path as the counterpart of the board-level PS/2 receiver, so scan-code sequences can be driven into the keyboard input without the board's keyboard model. The block transmits only; host-to-device commands are not supported.

## Interface
- `CLK_DIV`, default 4: system cycles per PS/2 half-period. Must be ≥2.
- `GAP_CYCLES`, default 32: idle cycles inserted after every frame. Must be ≥1.
- `FIFO_DEPTH`, default 4: scan-code FIFO entries. Power of 2, ≥2.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `code_valid` in 1: a scan code is offered.
- `code_data` in 8: scan code byte.
- `code_ready` out 1: FIFO can accept; equals not full.
- `ps2_clk` out 1: PS/2 clock, registered, idles high.
- `ps2_data` out 1: PS/2 data, registered, idles high.
- `busy` out 1: a frame or gap is in progress, or the FIFO is non-empty.

## Operation
- **Push:** a push occurs when `code_valid && code_ready` on a rising edge. The FIFO is in-order.
- **Full FIFO:** `code_ready` is 0 and nothing is written. Ready is computed from the current count, so a same-cycle pop does not allow a push.
- **Frame format:** frame bits b0..b10 are
  - b0: start bit, 0.
  - b1–b8: `code_data` bits [0] to [7], LSB first.
  - b9: odd parity, i.e. ~^data, so the ones in data plus parity total an odd number.
  - b10: stop bit, 1.
- **FSM states:** IDLE, HIGH, LOW, GAP. A bit index (0..10) and a half-period counter (0..CLK_DIV-1) are kept.
- **IDLE:**
  - If the FIFO is non-empty: pop, load the 11-bit shift register, bit index = 0, go to HIGH.
  - `ps2_clk` = `ps2_data` = 1.
- **HIGH:**
  - `ps2_clk` = 1, `ps2_data` = current bit.
  - After CLK_DIV cycles, go to LOW.
- **LOW:**
  - `ps2_clk` = 0; `ps2_data` is held.
  - After CLK_DIV cycles: if bit index is 10, go to GAP; otherwise increment the bit index and go to HIGH.
- **GAP:**
  - `ps2_clk` = `ps2_data` = 1 for GAP_CYCLES cycles, then go to IDLE.
- **Data stability:** `ps2_data` changes only on entry to HIGH, which guarantees CLK_DIV cycles of setup before each falling edge of `ps2_clk` and CLK_DIV cycles of hold after it.
- **busy:** 1 when the state is not IDLE or the FIFO count is non-zero.

## Timing
- **Reset values:** `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0, `code_ready` = 1. The FIFO is empty and the FSM is in IDLE.
- **Reset mid-frame:** takes effect immediately and asynchronously. Both lines go high, the current frame is aborted, and all queued codes are discarded. Pushes while `rst` is low are ignored.
- **Latency:**
  - Push at edge T into an empty FIFO with the FSM in IDLE → pop at edge T+1 → `ps2_data` = 0 (start bit) from edge T+2.
  - First `ps2_clk` falling edge is at T+2+CLK_DIV.
- **Frame duration:** 22·CLK_DIV cycles from the start of HIGH for b0 to the end of LOW for b10, followed by GAP_CYCLES cycles, then one IDLE cycle before the next start bit.
  - With CLK_DIV = 4 and GAP_CYCLES = 32: start bits of back-to-back frames are 88+32+1 = 121 cycles apart.
- **Ready latency:** `code_ready` reflects the FIFO count after the edge; it reasserts in the cycle after the pop that made room.
- **Simultaneous push and pop (FIFO not full):** the count is unchanged and both operations succeed.

## Test plan
- **Single code 0x1C (CLK_DIV = 4):**
  - Stimulus: one push of 0x1C.
  - Required: `ps2_data` sampled at the 11 `ps2_clk` falling edges = 0, 0,0,1,1,1,0,0,0, 0, 1 (parity 0).
  - Required: each low/high phase lasts exactly 4 cycles; lines are high for 32 cycles afterwards; `busy` drops when GAP ends.
- **Parity corners:**
  - 0x00 → parity 1.
  - 0xFF → parity 1.
  - 0x01 → parity 0.
  - In every case the stop bit is 1 and the total ones count over b1–b9 is odd.
- **Burst of 6 codes 0x10–0x15 pushed on consecutive cycles:**
  - `code_ready` falls after the FIFO holds 4 entries, with the first code already popped into the shifter.
  - The remaining code is pushed when `code_ready` reasserts.
  - All six codes are transmitted in order, with start bits 121 cycles apart.
- **Full-FIFO hold:**
  - Stimulus: `code_valid` held high with changing `code_data` while `code_ready` = 0.
  - Required: no extra or corrupted entries; transmitted bytes match exactly the accepted handshakes.
- **Reset during b5 of a frame with 2 codes queued:**
  - Required: `ps2_clk`/`ps2_data` go to 1 with no clock edge in between.
  - After reset release: `busy` = 0, `code_ready` = 1, and no further frames are sent.
  - A new push of 0x5A then transmits correctly.
- **Data stability check (CLK_DIV = 2):**
  - Stimulus: continuous random traffic.
  - Required: the assertion "`ps2_data` never changes while `ps2_clk` = 0 or within the same cycle as a `ps2_clk` fall" holds.
  - Required: every decoded byte equals the pushed byte.
